// File: rtl/crossing_sensor_driver_if.sv
// crossing_sensor_driver_if: start/dir/abort request side and E/W/busy/done drive side of the crossing driver
interface crossing_sensor_driver_if;
  logic start;
  logic dir;
  logic abort;
  logic E;
  logic W;
  logic busy;
  logic done;
  modport master(output start, dir, abort, input E, W, busy, done);
  modport slave(input start, dir, abort, output E, W, busy, done);
endinterface

// File: rtl/crossing_sensor_driver.sv
// crossing_sensor_driver: on start, emits the lead -> both -> trail sensor sequence of a passing object
// with DWELL cycles per phase, then a one-cycle done pulse.
module crossing_sensor_driver #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  crossing_sensor_driver_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEAD, BOTH, TRAIL, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d, e_q, e_d, w_q, w_d, busy_q, busy_d, done_q, done_d;
  logic wrap, lead, trail;
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    wrap = cnt_q == LAST;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = LEAD;
        dir_d = bus.dir;
      end
      LEAD: state_d = bus.abort ? IDLE : wrap ? BOTH : LEAD;
      BOTH: state_d = bus.abort ? IDLE : wrap ? TRAIL : BOTH;
      TRAIL: state_d = bus.abort ? IDLE : wrap ? DONE : TRAIL;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    // Outputs are decoded from the next state so the registers line up with the state change
    lead = state_d == LEAD || state_d == BOTH;
    trail = state_d == BOTH || state_d == TRAIL;
    e_d = dir_d ? trail : lead;
    w_d = dir_d ? lead : trail;
    busy_d = lead || trail;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dir_q <= 1'b0;
      e_q <= 1'b0;
      w_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      e_q <= e_d;
      w_q <= w_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.E = e_q;
  assign bus.W = w_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
